// File: rtl/simd_mult_issue_ctrl.sv
// simd_mult_issue_ctrl
//   Packs a stream of 10x9-bit unsigned operand pairs two at a time onto a
//   two-lane SIMD multiplier, then unpacks the lane products back into a
//   single in-order result stream.
//
//   Ports
//     clock_i, reset_i            clock, async active-high reset
//     in_valid_i/in_ready_o       operand handshake, in_a_i (10b), in_b_i (9b)
//     flush_i                     issue a held lane-0 operand on its own
//     mul_a0_o..mul_b1_o          lane operands to the DSP, mul_issue_o strobe
//     mul_z0_i, mul_z1_i          lane products, LATENCY cycles after issue
//     out_valid_o/out_ready_i     result handshake, out_z_o (19b)
//
//   Issue is gated by a credit count (buffered + in-flight pairs), so the
//   result FIFO can never overflow and products are never dropped.
module simd_mult_issue_ctrl #(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [9:0]  in_a_i,
  input  logic [8:0]  in_b_i,
  input  logic        flush_i,
  output logic [9:0]  mul_a0_o,
  output logic [8:0]  mul_b0_o,
  output logic [9:0]  mul_a1_o,
  output logic [8:0]  mul_b1_o,
  output logic        mul_issue_o,
  input  logic [18:0] mul_z0_i,
  input  logic [18:0] mul_z1_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [18:0] out_z_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic {EMPTY, HALF} pair_t;
  typedef enum logic {LANE0, LANE1} lane_t;

  pair_t pstate;
  lane_t ustate;

  logic [9:0]          hold_a;
  logic [8:0]          hold_b;
  logic [CW-1:0]       credit;
  logic [CW-1:0]       occ;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  // stage k is high during cycle t+k of an issue at cycle t
  logic [LATENCY-1:0]  vld_pipe, sgl_pipe;

  logic [18:0]          fifo_z0 [FIFO_DEPTH];
  logic [18:0]          fifo_z1 [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_sgl;

  logic has_credit, accept, issue_pair, issue_single, issue;
  logic push, hs, pop;

  always_comb begin
    has_credit   = credit < DEPTH;
    in_ready_o   = (pstate == EMPTY) || has_credit;
    accept       = in_valid_i && in_ready_o;
    issue_pair   = (pstate == HALF) && accept;
    // a new operand takes priority over flush; flush is only sampled, never stored
    issue_single = (pstate == HALF) && flush_i && !in_valid_i && has_credit;
    issue        = issue_pair || issue_single;
    push         = vld_pipe[LATENCY-1];
    out_valid_o  = occ != '0;
    hs           = out_valid_o && out_ready_i;
    // a single pair pops on its lane-0 handshake, a full pair on lane 1
    pop          = hs && ((ustate == LANE1) || fifo_sgl[rd_ptr]);
    out_z_o      = '0;
    if (out_valid_o)
      out_z_o = (ustate == LANE0) ? fifo_z0[rd_ptr] : fifo_z1[rd_ptr];
  end

  assign mul_issue_o = vld_pipe[0];

  // pairing FSM and registered lane operands
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pstate   <= EMPTY;
      hold_a   <= '0;
      hold_b   <= '0;
      mul_a0_o <= '0;
      mul_b0_o <= '0;
      mul_a1_o <= '0;
      mul_b1_o <= '0;
    end else begin
      case (pstate)
        EMPTY: if (accept) begin
          hold_a <= in_a_i;
          hold_b <= in_b_i;
          pstate <= HALF;
        end
        HALF: if (issue_pair) begin
          mul_a0_o <= hold_a;
          mul_b0_o <= hold_b;
          mul_a1_o <= in_a_i;
          mul_b1_o <= in_b_i;
          pstate   <= EMPTY;
        end else if (issue_single) begin
          mul_a0_o <= hold_a;
          mul_b0_o <= hold_b;
          mul_a1_o <= '0;
          mul_b1_o <= '0;
          pstate   <= EMPTY;
        end
        default: pstate <= EMPTY;
      endcase
    end
  end

  // valid / single-tag pipeline tracking the DSP latency
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      vld_pipe <= '0;
      sgl_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      sgl_pipe[0] <= issue_single;
      for (int k = 1; k < LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        sgl_pipe[k] <= sgl_pipe[k-1];
      end
    end
  end

  // credit = buffered + in-flight pairs; issue and pop may cancel out
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) credit <= '0;
    else         credit <= credit + CW'(issue) - CW'(pop);
  end

  // result FIFO control
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      fifo_sgl <= '0;
    end else begin
      occ <= occ + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr           <= wr_ptr + AW'(1);
        fifo_sgl[wr_ptr] <= sgl_pipe[LATENCY-1];
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // product storage needs no reset: reads are gated by occupancy
  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_z0[wr_ptr] <= mul_z0_i;
      fifo_z1[wr_ptr] <= mul_z1_i;
    end
  end

  // unpack FSM
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) ustate <= LANE0;
    else if (hs) begin
      case (ustate)
        LANE0:   if (!fifo_sgl[rd_ptr]) ustate <= LANE1;
        LANE1:   ustate <= LANE0;
        default: ustate <= LANE0;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_mult_issue_ctrl.sv
module tb_simd_mult_issue_ctrl;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clock_i = 0;
  logic        reset_i = 1;
  logic        in_valid_i, in_ready_o, flush_i;
  logic [9:0]  in_a_i, mul_a0_o, mul_a1_o;
  logic [8:0]  in_b_i, mul_b0_o, mul_b1_o;
  logic        mul_issue_o, out_valid_o, out_ready_i;
  logic [18:0] mul_z0_i, mul_z1_i, out_z_o;

  always #5 clock_i = ~clock_i;

  simd_mult_issue_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .flush_i(flush_i),
    .mul_a0_o(mul_a0_o), .mul_b0_o(mul_b0_o),
    .mul_a1_o(mul_a1_o), .mul_b1_o(mul_b1_o),
    .mul_issue_o(mul_issue_o),
    .mul_z0_i(mul_z0_i), .mul_z1_i(mul_z1_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_z_o(out_z_o)
  );

  // DSP model: one register stage, so products appear LAT-1 cycles after issue
  logic [18:0] d0 = '0, d1 = '0;
  always @(posedge clock_i) begin
    d0 <= mul_a0_o * mul_b0_o;
    d1 <= mul_a1_o * mul_b1_o;
  end
  assign mul_z0_i = d0;
  assign mul_z1_i = d1;

  int total = 0, passed = 0, cyc = 0;
  int issue_cnt = 0, acc_cnt = 0;
  int sb[$];
  int out_log[$];
  int out_cyc[$];
  logic [37:0] issue_log[$];
  bit stall = 0;
  int stall_z = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(posedge clock_i) cyc++;

  // Reference: every accepted operand must come out as a*b, in arrival order.
  always @(negedge clock_i) begin
    if (reset_i) stall = 0;
    else begin
      if (stall) begin
        check("hold_valid", out_valid_o, 1);
        check("hold_z", out_z_o, stall_z);
      end
      if (mul_issue_o) begin
        issue_cnt++;
        issue_log.push_back({mul_a0_o, mul_b0_o, mul_a1_o, mul_b1_o});
      end
      if (in_valid_i && in_ready_o) begin
        acc_cnt++;
        sb.push_back(int'(in_a_i) * int'(in_b_i));
      end
      if (out_valid_o && out_ready_i) begin
        out_log.push_back(int'(out_z_o));
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          $display("FAIL spurious_output: got %0d with nothing outstanding", out_z_o);
        end else check("order", out_z_o, sb.pop_front());
      end
      stall   = out_valid_o && !out_ready_i;
      stall_z = int'(out_z_o);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock_i); #1; end
  endtask

  task automatic send(input logic [9:0] a, input logic [8:0] b);
    int n = 0;
    in_valid_i = 1; in_a_i = a; in_b_i = b;
    @(negedge clock_i);
    while (!in_ready_o && n < 300) begin @(negedge clock_i); n++; end
    if (n >= 300) check("send_timeout", in_ready_o, 1);
    @(posedge clock_i); #1;
    in_valid_i = 0;
  endtask

  task automatic wait_log(input int n, input string name);
    int k = 0;
    while (out_log.size() < n && k < 300) begin @(posedge clock_i); #1; k++; end
    check(name, out_log.size() >= n, 1);
  endtask

  function automatic logic [9:0] opa(input int i);
    return 10'((37 * i + 1) % 1024);
  endfunction
  function automatic logic [8:0] opb(input int i);
    return 9'((19 * i + 2) % 512);
  endfunction

  typedef struct {
    logic [9:0] a;
    logic [8:0] b;
    int         z;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_out, b_iss, acc0, k;
    vecs[0] = '{10'd3,    9'd5,   15};
    vecs[1] = '{10'd10,   9'd9,   90};
    vecs[2] = '{10'd1023, 9'd511, 522753};
    vecs[3] = '{10'd0,    9'd511, 0};
    vecs[4] = '{10'd1023, 9'd0,   0};
    vecs[5] = '{10'd1,    9'd1,   1};
    vecs[6] = '{10'd512,  9'd256, 131072};
    vecs[7] = '{10'd1000, 9'd500, 500000};

    in_valid_i = 0; in_a_i = 0; in_b_i = 0; flush_i = 0; out_ready_i = 1;
    idle(2);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_issue", mul_issue_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_z", out_z_o, 0);
    check("rst_lanes", {mul_a0_o, mul_b0_o, mul_a1_o, mul_b1_o}, 0);
    reset_i = 0;
    idle(1);

    // single pair, LATENCY 2
    b_out = out_log.size(); b_iss = issue_cnt;
    send(3, 5); send(10, 9);
    wait_log(b_out + 2, "pair_wait");
    idle(4);
    check("pair_issue_cnt", issue_cnt - b_iss, 1);
    check("pair_lanes", issue_log[$], {10'd3, 9'd5, 10'd10, 9'd9});
    check("pair_z0", out_log[b_out], 15);
    check("pair_z1", out_log[b_out+1], 90);
    check("pair_consec", out_cyc[b_out+1] - out_cyc[b_out], 1);
    check("pair_count", out_log.size() - b_out, 2);

    // table vectors, including extreme operands
    b_out = out_log.size();
    for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b);
    wait_log(b_out + 8, "vec_wait");
    for (int i = 0; i < 8; i++) check($sformatf("vec%0d", i), out_log[b_out+i], vecs[i].z);

    // flush of a held half-pair
    b_out = out_log.size(); b_iss = issue_cnt;
    send(1023, 511);
    flush_i = 1; idle(1); flush_i = 0;
    wait_log(b_out + 1, "flush_wait");
    idle(6);
    check("flush_count", out_log.size() - b_out, 1);
    check("flush_z", out_log[b_out], 1023 * 511);
    check("flush_lanes", issue_log[$], {10'd1023, 9'd511, 19'd0});
    check("flush_issues", issue_cnt - b_iss, 1);
    check("flush_hold_a0", mul_a0_o, 1023);
    check("flush_hold_a1", mul_a1_o, 0);

    // flush while empty does nothing
    b_iss = issue_cnt;
    flush_i = 1; idle(3); flush_i = 0; idle(3);
    check("flush_empty_issue", issue_cnt - b_iss, 0);
    check("flush_empty_ready", in_ready_o, 1);

    // backpressure: 4 pairs fill the credit, the 10th operand stalls in HALF
    out_ready_i = 0;
    b_out = out_log.size(); b_iss = issue_cnt;
    for (int i = 0; i < 9; i++) send(opa(i), opb(i));
    in_valid_i = 1; in_a_i = opa(9); in_b_i = opb(9);
    idle(3);
    check("bp_in_ready", in_ready_o, 0);
    check("bp_issues", issue_cnt - b_iss, 4);
    check("bp_out_valid", out_valid_o, 1);
    check("bp_no_out", out_log.size() - b_out, 0);
    out_ready_i = 1;
    for (int i = 9; i < 12; i++) send(opa(i), opb(i));
    wait_log(b_out + 12, "bp_wait");
    idle(4);
    check("bp_count", out_log.size() - b_out, 12);
    check("bp_last", out_log[b_out+11], int'(opa(11)) * int'(opb(11)));
    check("bp_sb_empty", sb.size(), 0);

    // flush waits for credit and is not remembered
    out_ready_i = 0;
    b_out = out_log.size(); b_iss = issue_cnt;
    for (int i = 0; i < 9; i++) send(opa(i + 20), opb(i + 20));
    flush_i = 1; idle(4);
    check("fw_blocked", issue_cnt - b_iss, 4);
    flush_i = 0; out_ready_i = 1;
    wait_log(b_out + 8, "fw_drain");
    idle(4);
    check("fw_not_latched", issue_cnt - b_iss, 4);
    check("fw_held_out", out_log.size() - b_out, 8);
    flush_i = 1; idle(1); flush_i = 0;
    wait_log(b_out + 9, "fw_wait");
    idle(3);
    check("fw_issues", issue_cnt - b_iss, 5);
    check("fw_z", out_log[b_out+8], int'(opa(28)) * int'(opb(28)));
    check("fw_lane1_zero", issue_log[$][18:0], 0);

    // random traffic with random backpressure and flushes
    b_iss = issue_cnt; acc0 = acc_cnt; k = 0;
    while (acc_cnt - acc0 < 200 && k < 6000) begin
      in_valid_i  = $urandom_range(0, 3) != 0;
      in_a_i      = 10'($urandom);
      in_b_i      = 9'($urandom);
      flush_i     = $urandom_range(0, 7) == 0;
      out_ready_i = $urandom_range(0, 2) != 0;
      idle(1);
      k++;
    end
    in_valid_i = 0;
    check("rnd_budget", acc_cnt - acc0 >= 200, 1);
    out_ready_i = 1; flush_i = 1; idle(3); flush_i = 0;
    k = 0;
    while (sb.size() != 0 && k < 300) begin idle(1); k++; end
    check("rnd_drain", sb.size(), 0);
    check("rnd_wraps", issue_cnt - b_iss > 20 * DEPTH, 1);

    // reset during an issue cycle with results buffered and in flight
    out_ready_i = 0;
    send(11, 3); send(12, 3); send(13, 3); send(14, 3);
    idle(4);
    check("mid_buffered", out_valid_o, 1);
    send(5, 5); send(6, 6);
    check("mid_issue_cycle", mul_issue_o, 1);
    reset_i = 1;
    sb.delete();
    #1;
    check("mid_out_valid", out_valid_o, 0);
    check("mid_issue", mul_issue_o, 0);
    check("mid_out_z", out_z_o, 0);
    check("mid_in_ready", in_ready_o, 1);
    idle(2);
    reset_i = 0; out_ready_i = 1;
    b_out = out_log.size();
    idle(8);
    check("mid_no_stale", out_log.size() - b_out, 0);
    send(2, 2); send(4, 4);
    wait_log(b_out + 2, "mid_wait");
    idle(6);
    check("mid_count", out_log.size() - b_out, 2);
    check("mid_z0", out_log[b_out], 4);
    check("mid_z1", out_log[b_out+1], 16);
    check("mid_lanes", issue_log[$], {10'd2, 9'd2, 10'd4, 9'd4});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
